// File: rtl/ov7670_stream_gen_if.sv
// OV7670 camera-side pixel bus: pixel clock, frame/line syncs, data byte.
// The stream generator drives it; the capture receiver listens.
interface ov7670_stream_gen_if;
    logic       PCLK;
    logic       VSYNC;
    logic       HREF;
    logic [7:0] D;

    modport master (output PCLK, VSYNC, HREF, D);
    modport slave  (input  PCLK, VSYNC, HREF, D);
endinterface

// File: rtl/ov7670_stream_gen.sv
// OV7670 VGA YCbCr 4:2:2 stream generator: bars, gradient, moving square, black.
// Outputs change on the PCLK falling edge and hold across the rising edge.
module ov7670_stream_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 288,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 17,
    parameter int V_ACTIVE  = 480,
    parameter int VFP_LINES = 10,
    parameter int SQ_SIZE   = 32
) (
    input  logic                CLOCK_24,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    ov7670_stream_gen_if.master cam,
    output logic                frame_done,
    output logic [7:0]          frame_cnt
);
    localparam int LINE_B  = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_L = VS_LINES + VBP_LINES + V_ACTIVE + VFP_LINES;
    localparam int BW      = $clog2(LINE_B);
    localparam int LW      = $clog2(FRAME_L);
    localparam int SQ_Y    = 224;

    localparam logic [BW-1:0] B_LAST = BW'(LINE_B - 1);
    localparam logic [BW-1:0] B_ACT  = BW'(2 * H_ACTIVE);
    localparam logic [LW-1:0] L_LAST = LW'(FRAME_L - 1);
    localparam logic [LW-1:0] L_VBP  = LW'(VS_LINES);
    localparam logic [LW-1:0] L_ACT  = LW'(VS_LINES + VBP_LINES);
    localparam logic [LW-1:0] L_VFP  = LW'(VS_LINES + VBP_LINES + V_ACTIVE);
    localparam logic [9:0]    SQ_MAX = 10'(H_ACTIVE - SQ_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VS,
        S_VBP,
        S_ACT,
        S_VFP
    } state_t;

    state_t        state_q, state_d;
    logic          ph_q;
    logic [BW-1:0] byte_q, byte_d;
    logic [LW-1:0] line_q, line_d;
    logic [1:0]    mode_q, mode_d;
    logic [9:0]    sq_x_q, sq_x_d, sq_inc;
    logic          fd_q, fd_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic          vs_q, vs_d;
    logic          href_q, href_d;
    logic [7:0]    d_q, d_d;
    logic          start;

    logic [9:0]    x, px, y;
    logic [10:0]   sq_hi;
    logic          in_sq;
    logic [7:0]    pix_y, pix_cb, pix_cr, sel;

    // Position (byte_d, line_d) is the byte that goes out after this step
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        line_d  = line_q;
        mode_d  = mode_q;
        sq_x_d  = sq_x_q;
        fcnt_d  = fcnt_q;
        fd_d    = 1'b0;
        start   = 1'b0;
        sq_inc  = sq_x_q + 10'd4;
        if (ph_q) begin
            if (state_q == S_IDLE) begin
                start = en;
            end else if (byte_q == B_LAST && line_q == L_LAST) begin
                fd_d    = 1'b1;
                fcnt_d  = fcnt_q + 8'd1;
                sq_x_d  = (sq_inc > SQ_MAX) ? '0 : sq_inc;
                start   = en;
                state_d = S_IDLE;
                byte_d  = '0;
                line_d  = '0;
            end else begin
                if (byte_q == B_LAST) begin
                    byte_d = '0;
                    line_d = line_q + LW'(1);
                end else begin
                    byte_d = byte_q + BW'(1);
                end
                unique case (1'b1)
                    line_d < L_VBP:                    state_d = S_VS;
                    line_d >= L_VBP && line_d < L_ACT: state_d = S_VBP;
                    line_d >= L_ACT && line_d < L_VFP: state_d = S_ACT;
                    default:                           state_d = S_VFP;
                endcase
            end
            if (start) begin
                state_d = S_VS;
                byte_d  = '0;
                line_d  = '0;
                mode_d  = mode;
            end
        end
    end

    // Chroma bytes take the even pixel of the pair
    always_comb begin
        x      = 10'(byte_d >> 1);
        px     = byte_d[0] ? x : {x[9:1], 1'b0};
        y      = 10'(line_d - L_ACT);
        sq_hi  = {1'b0, sq_x_q} + 11'(SQ_SIZE);
        in_sq  = px >= sq_x_q && {1'b0, px} < sq_hi &&
                 y >= 10'(SQ_Y) && y < 10'(SQ_Y + SQ_SIZE);
        pix_y  = 8'd16;
        pix_cb = 8'd128;
        pix_cr = 8'd128;
        unique case (mode_d)
            2'd0: begin
                if (px < 10'd160) begin
                    pix_y = 8'd81;  pix_cb = 8'd90;  pix_cr = 8'd240;
                end else if (px < 10'd320) begin
                    pix_y = 8'd145; pix_cb = 8'd54;  pix_cr = 8'd34;
                end else if (px < 10'd480) begin
                    pix_y = 8'd210; pix_cb = 8'd16;  pix_cr = 8'd146;
                end else begin
                    pix_y = 8'd41;  pix_cb = 8'd240; pix_cr = 8'd110;
                end
            end
            2'd1: pix_y = px[9:2];
            2'd2: begin
                if (in_sq) begin
                    pix_y = 8'd145; pix_cb = 8'd54; pix_cr = 8'd34;
                end
            end
            default: ;
        endcase
        sel = pix_y;
        unique case (byte_d[1:0])
            2'd0:    sel = pix_cb;
            2'd2:    sel = pix_cr;
            default: sel = pix_y;
        endcase
        vs_d   = state_d == S_VS;
        href_d = state_d == S_ACT && byte_d < B_ACT;
        d_d    = href_d ? sel : 8'd0;
    end

    always_ff @(posedge CLOCK_24) begin
        if (!rst) begin
            ph_q    <= 1'b0;
            state_q <= S_IDLE;
            byte_q  <= '0;
            line_q  <= '0;
            mode_q  <= '0;
            sq_x_q  <= '0;
            fd_q    <= 1'b0;
            fcnt_q  <= '0;
            vs_q    <= 1'b0;
            href_q  <= 1'b0;
            d_q     <= '0;
        end else begin
            ph_q <= ~ph_q;
            fd_q <= fd_d;
            if (ph_q) begin
                state_q <= state_d;
                byte_q  <= byte_d;
                line_q  <= line_d;
                mode_q  <= mode_d;
                sq_x_q  <= sq_x_d;
                fcnt_q  <= fcnt_d;
                vs_q    <= vs_d;
                href_q  <= href_d;
                d_q     <= d_d;
            end
        end
    end

    assign cam.PCLK   = ph_q;
    assign cam.VSYNC  = vs_q;
    assign cam.HREF   = href_q;
    assign cam.D      = d_q;
    assign frame_done = fd_q;
    assign frame_cnt  = fcnt_q;
endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen: three shrunken geometries
// cover bars/gradient, frame timing/reset, and the moving square.
module tb_ov7670_stream_gen;
    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, en_b, en_c;
    logic [1:0] mode_a, mode_b, mode_c;
    logic       fd_a, fd_b, fd_c;
    logic [7:0] fc_a, fc_b, fc_c;

    logic       fd [3];
    logic [7:0] fc [3];
    logic       pc [3];
    logic       vs [3];
    logic       hr [3];
    logic [7:0] dd [3];

    logic [7:0] ln [1280];
    int         ln_n;
    int         n_chk = 0;
    int         n_pass = 0;

    ov7670_stream_gen_if if_a ();
    ov7670_stream_gen_if if_b ();
    ov7670_stream_gen_if if_c ();

    always #5 clk = ~clk;

    ov7670_stream_gen #(
        .H_ACTIVE(640), .H_BLANK(8), .VS_LINES(1), .VBP_LINES(1),
        .V_ACTIVE(2), .VFP_LINES(1), .SQ_SIZE(32)
    ) u_a (
        .CLOCK_24(clk), .rst(rst), .en(en_a), .mode(mode_a),
        .cam(if_a), .frame_done(fd_a), .frame_cnt(fc_a)
    );

    ov7670_stream_gen #(
        .H_ACTIVE(8), .H_BLANK(4), .VS_LINES(1), .VBP_LINES(1),
        .V_ACTIVE(4), .VFP_LINES(1), .SQ_SIZE(4)
    ) u_b (
        .CLOCK_24(clk), .rst(rst), .en(en_b), .mode(mode_b),
        .cam(if_b), .frame_done(fd_b), .frame_cnt(fc_b)
    );

    ov7670_stream_gen #(
        .H_ACTIVE(8), .H_BLANK(4), .VS_LINES(1), .VBP_LINES(1),
        .V_ACTIVE(228), .VFP_LINES(1), .SQ_SIZE(4)
    ) u_c (
        .CLOCK_24(clk), .rst(rst), .en(en_c), .mode(mode_c),
        .cam(if_c), .frame_done(fd_c), .frame_cnt(fc_c)
    );

    assign fd[0] = fd_a;      assign fd[1] = fd_b;      assign fd[2] = fd_c;
    assign fc[0] = fc_a;      assign fc[1] = fc_b;      assign fc[2] = fc_c;
    assign pc[0] = if_a.PCLK; assign pc[1] = if_b.PCLK; assign pc[2] = if_c.PCLK;
    assign vs[0] = if_a.VSYNC; assign vs[1] = if_b.VSYNC; assign vs[2] = if_c.VSYNC;
    assign hr[0] = if_a.HREF; assign hr[1] = if_b.HREF; assign hr[2] = if_c.HREF;
    assign dd[0] = if_a.D;    assign dd[1] = if_b.D;    assign dd[2] = if_c.D;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic wait_hi(input int s, input bit on_vs, input int lim,
                           output int n);
        n = 0;
        while (!(on_vs ? vs[s] : hr[s]) && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!(on_vs ? vs[s] : hr[s])) check("wait_tmo", n, lim - 1);
    endtask

    task automatic wait_fd(input int s, input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fd[s] && n < lim);
        if (!fd[s]) check("fd_tmo", n, lim - 1);
    endtask

    // Capture one HREF-high line, one byte per PCLK-high sample
    task automatic get_line(input int s);
        int n = 0;
        ln_n = 0;
        while (!(hr[s] && pc[s]) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40000) check("line_tmo", n, 0);
        while (hr[s] && ln_n < 1280) begin
            if (pc[s]) begin
                ln[ln_n] = dd[s];
                ln_n++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int   n, cnt, tg, nz, t, bad, rises, bytes, idx, y, grn, cb;
        int   xmin, xmax, ymin, ymax, sq;
        logic prev, prevh;

        rst = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        mode_a = 2'd0; mode_b = 2'd0; mode_c = 2'd0;
        repeat (5) @(negedge clk);
        check("rst_pclk", pc[0], 0);
        check("rst_vsync", vs[0], 0);
        check("rst_href", hr[0], 0);
        check("rst_d", dd[0], 0);
        check("rst_fd", fd[0], 0);
        check("rst_fcnt", fc[0], 0);
        tg = 0;
        prev = pc[0];
        repeat (4) begin
            @(negedge clk);
            if (pc[0] != prev) tg++;
            prev = pc[0];
        end
        check("rst_pclk_static", tg, 0);

        rst = 1'b1;
        tg = 0;
        nz = 0;
        prev = pc[0];
        repeat (1000) begin
            @(negedge clk);
            if (pc[0] != prev) tg++;
            prev = pc[0];
            if (vs[0] || hr[0] || dd[0] != 8'd0) nz++;
        end
        check("idle_pclk_toggles", tg, 1000);
        check("idle_outputs", nz, 0);
        check("idle_fcnt", fc[0], 0);

        // Full-width line: colour bars, then gradient on the next frame
        en_a = 1'b1;
        mode_a = 2'd0;
        wait_hi(0, 1'b1, 10, n);
        check("a_vs_latency_le2", int'(n <= 2), 1);
        cnt = 0;
        while (vs[0] && cnt < 20000) begin
            @(negedge clk);
            cnt++;
        end
        check("a_vs_clocks", cnt, 2576);
        wait_hi(0, 1'b0, 20000, n);
        check("a_vs_to_href", cnt + n, 5152);
        get_line(0);
        check("a_href_bytes", ln_n, 1280);
        check("a_b0_cb", ln[0], 90);
        check("a_b1_y", ln[1], 81);
        check("a_b2_cr", ln[2], 240);
        check("a_b3_y", ln[3], 81);
        check("a_x159_cr", ln[318], 240);
        check("a_x160_cb", ln[320], 54);
        check("a_x160_y", ln[321], 145);
        check("a_x160_cr", ln[322], 34);
        check("a_x161_y", ln[323], 145);
        check("a_x320_cb", ln[640], 16);
        check("a_x320_y", ln[641], 210);
        check("a_x320_cr", ln[642], 146);
        check("a_x480_cb", ln[960], 240);
        check("a_x480_y", ln[961], 41);
        check("a_x480_cr", ln[962], 110);
        check("a_blank_d", dd[0], 0);

        mode_a = 2'd1;
        get_line(0);
        check("a_mode_held", ln[1], 81);
        wait_fd(0, 20000, n);
        check("a_b2b_vsync", vs[0], 1);
        check("a_fcnt1", fc[0], 1);
        get_line(0);
        check("a_grad_x0", ln[1], 0);
        check("a_grad_x4", ln[9], 1);
        check("a_grad_x320", ln[641], 80);
        check("a_grad_x639", ln[1279], 159);
        bad = 0;
        for (int i = 0; i < 1280; i += 2)
            if (ln[i] != 8'd128) bad++;
        check("a_grad_chroma", bad, 0);
        en_a = 1'b0;

        // Small geometry: 7 lines x 20 bytes x 2 = 280 clocks per frame
        en_b = 1'b1;
        mode_b = 2'd3;
        wait_fd(1, 400, n);
        check("b_fcnt1", fc[1], 1);
        wait_fd(1, 400, n);
        check("b_period", n, 280);
        check("b_fcnt2", fc[1], 2);
        rises = 0; bytes = 0; bad = 0; idx = 0; t = 0;
        prevh = 1'b0;
        @(negedge clk);
        while (!fd[1] && t < 400) begin
            if (hr[1] && !prevh) begin
                rises++;
                idx = 0;
            end
            if (hr[1] && pc[1]) begin
                bytes++;
                if (int'(dd[1]) != ((idx % 2 == 1) ? 16 : 128)) bad++;
                idx++;
            end
            prevh = hr[1];
            @(negedge clk);
            t++;
        end
        if (t >= 400) check("b_scan_tmo", t, 399);
        check("b_href_pulses", rises, 4);
        check("b_href_bytes", bytes, 64);
        check("b_black_bytes", bad, 0);
        check("b_fcnt3", fc[1], 3);
        @(negedge clk);
        check("b_fd_width", fd[1], 0);
        repeat (100) @(negedge clk);
        en_b = 1'b0;
        wait_fd(1, 400, n);
        check("b_fcnt4", fc[1], 4);
        cnt = 0;
        repeat (400) begin
            @(negedge clk);
            cnt += int'(vs[1]) + int'(fd[1]);
        end
        check("b_idle_after_en_drop", cnt, 0);
        check("b_fcnt_hold", fc[1], 4);

        // Reset during ACT
        en_b = 1'b1;
        wait_hi(1, 1'b0, 400, n);
        rst = 1'b0;
        @(negedge clk);
        check("b_rst_vsync", vs[1], 0);
        check("b_rst_href", hr[1], 0);
        check("b_rst_d", dd[1], 0);
        check("b_rst_fcnt", fc[1], 0);
        check("b_rst_pclk", pc[1], 0);
        rst = 1'b1;
        wait_hi(1, 1'b1, 10, n);
        check("b_restart_latency_le2", int'(n <= 2), 1);
        cnt = 0;
        while (vs[1] && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("b_restart_vs_clocks", cnt, 40);
        en_b = 1'b0;

        // Moving square: 4x4 at y 224..227, sq_x 0, 4, then wraps to 0
        en_c = 1'b1;
        mode_c = 2'd2;
        for (int f = 0; f < 3; f++) begin
            wait_hi(2, 1'b1, 12000, n);
            xmin = 999; xmax = -1; ymin = 999; ymax = -1;
            grn = 0; bad = 0; cb = 0; y = -1; idx = 0; t = 0;
            prevh = 1'b0;
            @(negedge clk);
            while (!fd[2] && t < 12000) begin
                if (hr[2] && !prevh) begin
                    y++;
                    idx = 0;
                end
                if (hr[2] && pc[2]) begin
                    if (idx % 2 == 1) begin
                        if (dd[2] == 8'd145) begin
                            grn++;
                            if (idx / 2 < xmin) xmin = idx / 2;
                            if (idx / 2 > xmax) xmax = idx / 2;
                            if (y < ymin) ymin = y;
                            if (y > ymax) ymax = y;
                        end else if (dd[2] != 8'd16) begin
                            bad++;
                        end
                    end else if (dd[2] == 8'd54) begin
                        cb++;
                    end
                    idx++;
                end
                prevh = hr[2];
                @(negedge clk);
                t++;
            end
            if (t >= 12000) check("c_scan_tmo", t, 11999);
            sq = (f == 1) ? 4 : 0;
            check($sformatf("c_f%0d_xmin", f), xmin, sq);
            check($sformatf("c_f%0d_xmax", f), xmax, sq + 3);
            check($sformatf("c_f%0d_ymin", f), ymin, 224);
            check($sformatf("c_f%0d_ymax", f), ymax, 227);
            check($sformatf("c_f%0d_green", f), grn, 16);
            check($sformatf("c_f%0d_other_y", f), bad, 0);
            check($sformatf("c_f%0d_cb54", f), cb, 8);
        end
        en_c = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
